// File: rtl/evt6_sticky_latch.sv
// Six-line event capture: per-line synchronizer, edge/level capture, sticky W1C flags,
// registered masked OR output and first-event index for diagnosis.
module evt6_sticky_latch #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic       CK,
    input  logic       RN,
    input  logic [5:0] A,
    input  logic [5:0] MASK,
    input  logic [5:0] CLR,
    output logic [5:0] Q,
    output logic       Z0,
    output logic       FV,
    output logic [2:0] FIRST
);

    logic [SYNC_STAGES-1:0][5:0] sync_r;
    logic [5:0] prev_r;
    logic [5:0] q_r;
    logic       z0_r;
    logic       fv_r;
    logic [2:0] first_r;

    logic [5:0] sync_s;
    logic [5:0] cap_s;
    logic [5:0] q_next_s;
    logic       z0_next_s;
    logic       fv_next_s;
    logic [2:0] first_next_s;

    // Lowest set bit wins when several lines capture on the same edge.
    function automatic logic [2:0] lowest_idx(input logic [5:0] v);
        logic [2:0] idx;
        casez (v)
            6'b?????1: idx = 3'd0;
            6'b????10: idx = 3'd1;
            6'b???100: idx = 3'd2;
            6'b??1000: idx = 3'd3;
            6'b?10000: idx = 3'd4;
            6'b100000: idx = 3'd5;
            default:   idx = 3'd0;
        endcase
        return idx;
    endfunction

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchronizer chains plus one-cycle history of the synchronized level.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            sync_r <= '0;
            prev_r <= 6'b000000;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], A};
            prev_r <= sync_s;
        end
    end

    // Capture, sticky flag update (set beats clear) and first-event tracking.
    always_comb begin
        cap_s        = 6'b000000;
        q_next_s     = 6'b000000;
        z0_next_s    = 1'b0;
        fv_next_s    = fv_r;
        first_next_s = first_r;

        if (EDGE_MODE) begin
            cap_s = sync_s & ~prev_r;
        end else begin
            cap_s = sync_s;
        end

        q_next_s  = cap_s | (q_r & ~CLR);
        z0_next_s = |(q_next_s & MASK);

        if (q_next_s == 6'b000000) begin
            fv_next_s    = 1'b0;
            first_next_s = 3'd0;
        end else if (!fv_r) begin
            // FV low implies no flags were set, so a capture is the only way in.
            fv_next_s    = 1'b1;
            first_next_s = lowest_idx(cap_s);
        end else begin
            fv_next_s    = fv_r;
            first_next_s = first_r;
        end
    end

    // Output registers; every output comes straight from a flop.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            q_r     <= 6'b000000;
            z0_r    <= 1'b0;
            fv_r    <= 1'b0;
            first_r <= 3'd0;
        end else begin
            q_r     <= q_next_s;
            z0_r    <= z0_next_s;
            fv_r    <= fv_next_s;
            first_r <= first_next_s;
        end
    end

    assign Q     = q_r;
    assign Z0    = z0_r;
    assign FV    = fv_r;
    assign FIRST = first_r;

endmodule

// File: tb/tb_evt6_sticky_latch.sv
// Bench for evt6_sticky_latch: edge-mode (2 stages) and level-mode (3 stages) instances
// driven by shared directed + random stimulus, checked against a history-based model.
module tb_evt6_sticky_latch;

    logic       CK = 1'b0;
    logic       RN;
    logic [5:0] A, MASK, CLR;
    logic [5:0] q_e, q_l;
    logic       z0_e, z0_l, fv_e, fv_l;
    logic [2:0] first_e, first_l;

    int total = 0;
    int bad   = 0;

    // Model: list of A values sampled at each edge since reset release.
    logic [5:0] hist[$];
    int         ss[2] = '{2, 3};
    bit         md[2] = '{1'b1, 1'b0};
    logic [5:0] mq[2];
    logic       mz[2];
    logic       mfv[2];
    logic [2:0] mfirst[2];

    evt6_sticky_latch #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut (
        .CK(CK), .RN(RN), .A(A), .MASK(MASK), .CLR(CLR),
        .Q(q_e), .Z0(z0_e), .FV(fv_e), .FIRST(first_e)
    );

    evt6_sticky_latch #(.SYNC_STAGES(3), .EDGE_MODE(1'b0)) dut_lvl (
        .CK(CK), .RN(RN), .A(A), .MASK(MASK), .CLR(CLR),
        .Q(q_l), .Z0(z0_l), .FV(fv_l), .FIRST(first_l)
    );

    always #5 CK = ~CK;

    function automatic logic [5:0] past(int idx);
        if (idx < 1) return 6'b000000;
        return hist[idx-1];
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int m = 0; m < 2; m++) begin
            mq[m] = 6'b000000; mz[m] = 1'b0; mfv[m] = 1'b0; mfirst[m] = 3'd0;
        end
    endtask

    task automatic model_edge();
        int e;
        logic [5:0] sp, sp2, c, qn;
        hist.push_back(A);
        e = hist.size();
        for (int m = 0; m < 2; m++) begin
            // Synchronized level seen before this edge is A from ss edges ago.
            sp  = past(e - ss[m]);
            sp2 = past(e - ss[m] - 1);
            c   = md[m] ? (sp & ~sp2) : sp;
            qn  = c | (mq[m] & ~CLR);
            mz[m] = |(qn & MASK);
            if (qn == 6'b000000) begin
                mfv[m] = 1'b0; mfirst[m] = 3'd0;
            end else if (!mfv[m]) begin
                mfv[m] = 1'b1;
                for (int i = 5; i >= 0; i--) if (c[i]) mfirst[m] = 3'(i);
            end
            mq[m] = qn;
        end
    endtask

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("q_edge",      {2'b00, q_e},     {2'b00, mq[0]});
        check("z0_edge",     {7'd0, z0_e},     {7'd0, mz[0]});
        check("fv_edge",     {7'd0, fv_e},     {7'd0, mfv[0]});
        check("first_edge",  {5'd0, first_e},  {5'd0, mfirst[0]});
        check("q_level",     {2'b00, q_l},     {2'b00, mq[1]});
        check("z0_level",    {7'd0, z0_l},     {7'd0, mz[1]});
        check("fv_level",    {7'd0, fv_l},     {7'd0, mfv[1]});
        check("first_level", {5'd0, first_l},  {5'd0, mfirst[1]});
    endtask

    task automatic step(input logic [5:0] a, input logic [5:0] clr, input logic [5:0] mask);
        A = a; CLR = clr; MASK = mask;
        @(posedge CK);
        if (RN) model_edge();
        #1;
        check_all();
    endtask

    // Drop RN between edges, check outputs clear before the next edge, then release.
    task automatic async_reset_pulse();
        #2 RN = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 RN = 1'b1;
    endtask

    initial begin
        logic [5:0] ra, rc, rm;
        RN = 1'b0; A = 6'b000000; MASK = 6'h3F; CLR = 6'b000000;
        model_reset();
        #12;
        check_all();
        RN = 1'b1;

        // Latency: A[3] captured two edges after first sample in edge mode.
        step(6'b001000, 6'b000000, 6'h3F);
        step(6'b001000, 6'b000000, 6'h3F);
        step(6'b001000, 6'b000000, 6'h3F);
        check("lat_q3", {2'b00, q_e}, 8'h08);
        check("lat_first3", {5'd0, first_e}, 8'h03);
        repeat (3) step(6'b001000, 6'b000000, 6'h3F);

        // Clear and re-arm.
        step(6'b001000, 6'b001000, 6'h3F);
        repeat (3) step(6'b000000, 6'b000000, 6'h3F);
        repeat (3) step(6'b001000, 6'b000000, 6'h3F);

        // Set/clear collision on bit 1.
        repeat (4) step(6'b000000, 6'h3F, 6'h3F);
        repeat (3) step(6'b000010, 6'b000000, 6'h3F);
        repeat (2) step(6'b000000, 6'b000000, 6'h3F);
        step(6'b000010, 6'b000000, 6'h3F);
        step(6'b000010, 6'b000000, 6'h3F);
        step(6'b000010, 6'b000010, 6'h3F);

        // Simultaneous events, later event, partial and full clear.
        repeat (4) step(6'b000000, 6'h3F, 6'h3F);
        repeat (3) step(6'b100100, 6'b000000, 6'h3F);
        check("simul_first", {5'd0, first_e}, 8'h02);
        repeat (3) step(6'b100101, 6'b000000, 6'h3F);
        step(6'b100101, 6'b000100, 6'h3F);
        step(6'b100101, 6'h3F, 6'h3F);

        // Masking.
        repeat (4) step(6'b000000, 6'h3F, 6'h3F);
        repeat (3) step(6'b010000, 6'b000000, 6'h3F);
        repeat (2) step(6'b000000, 6'b000000, 6'h2F);
        step(6'b000000, 6'b000000, 6'h3F);

        // Level-mode hold under clear, then mid-operation async reset.
        repeat (5) step(6'b010000, 6'b010000, 6'h3F);
        #2 RN = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_q_level", {2'b00, q_l}, 8'h00);
        step(6'b010000, 6'b000000, 6'h3F);
        step(6'b010000, 6'b000000, 6'h3F);
        #3 RN = 1'b1;
        repeat (4) step(6'b010000, 6'b000000, 6'h3F);

        // Random phase: stretched toggles, sparse clears, occasional mask and reset.
        ra = 6'b000000; rc = 6'b000000; rm = 6'h3F;
        for (int n = 0; n < 400; n++) begin
            ra = ra ^ (6'($urandom) & 6'($urandom));
            rc = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b000000;
            if ($urandom_range(0, 15) == 0) rm = 6'($urandom);
            step(ra, rc, rm);
            if ($urandom_range(0, 99) == 0) async_reset_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/evt6_sticky_latch.md
Name: evt6_sticky_latch

Overview:
- Six-line event capture stage that sits directly upstream of the OR6 macro's usage point. It replaces a raw 6-input OR reduction wherever inputs are asynchronous or pulse-like.
- Synchronizes each of 6 request lines and detects each capture condition (edge or level).
- Holds each captured event in a sticky flag until software or logic clears it with write-1-to-clear.
- Drives one registered, glitch-free OR-reduced output Z0 over the unmasked flags, plus a first-event index for diagnosis.

Parameters:
SYNC_STAGES, 2, synchronizer flops per input line; legal range 2..4.
EDGE_MODE, 1, 1 = capture on synchronized rising edge; 0 = capture while synchronized level is high.

Ports:
CK  input  1  clock; all state updates on rising edge.
RN  input  1  asynchronous active-low reset; asserted (0) forces every register to its reset value immediately.
A  input  6  raw event lines, asynchronous to CK; bit i = event source i.
MASK  input  6  1 = flag i contributes to Z0; synchronous to CK; does not affect capture.
CLR  input  6  write-1-to-clear strobe per flag; synchronous, single-cycle or held.
Q  output  6  sticky event flags.
Z0  output  1  registered OR of (flags AND MASK).
FV  output  1  first-event index valid.
FIRST  output  3  index (0..5) of the first event captured since flags were last all-zero.

Behaviour:
- Reset (RN=0, async): sync chains=0, edge-history reg=0, Q=6'b0, Z0=0, FV=0, FIRST=3'd0. Release is synchronous in effect: the first state change can occur on the first CK edge with RN=1.
- Sync: per bit, a chain of SYNC_STAGES flops. S[i] = last-stage output.
- Capture condition C[i]:
  - EDGE_MODE=1: S[i] & ~P[i], where P[i] is S[i] delayed one clock (reset 0). A line already high at reset release therefore produces exactly one capture.
  - EDGE_MODE=0: C[i] = S[i].
- Latency: A[i] high and stable before edge k gives S[i]=1 after edge k+SYNC_STAGES-1, Q[i]=1 after edge k+SYNC_STAGES. Z0 and FIRST/FV update on that same edge.
- Flag update: Q_next[i] = C[i] | (Q[i] & ~CLR[i]).
  - Set wins over simultaneous clear: the event is never lost.
  - In EDGE_MODE=0 a flag cannot be cleared while its line stays high.
- Z0 register: Z0 <= |(Q_next & MASK).
  - Z0 follows Q changes with zero extra cycles.
  - A MASK change is reflected on the next edge.
- First-event tracking, evaluated per edge:
  - If Q_next==0: FV<=0, FIRST<=0.
  - Else if FV==0: FV<=1, FIRST<=lowest index i with C[i]=1. Ties are resolved lowest index wins.
  - Else: FIRST and FV hold. This holds even if flag FIRST is cleared while other flags remain set.
- Pulses on A shorter than one CK period may be missed. This is not an error condition; sources must stretch pulses to at least 1 CK period plus setup.
- Mid-operation reset: all flags and FV drop asynchronously. Events in flight inside the sync chain are discarded.
- No combinational path from any input to any output.

Test Plan:
- Reset/latency (SYNC_STAGES=2, EDGE_MODE=1): RN low, all outputs 0. Release RN, raise A[3] before edge k -> Q=6'b001000, Z0=1 (MASK=6'h3F), FV=1, FIRST=3 all after edge k+2. No change while A[3] stays high.
- Clear and re-arm: with Q[3]=1, pulse CLR=6'b001000 for 1 cycle -> Q=0, Z0=0, FV=0 next edge. Drop A[3], raise again -> Q[3]=1 after 2 edges.
- Set/clear collision: a new edge on A[1] synchronizes on the same edge that CLR[1]=1 -> Q[1] stays 1, Z0 stays 1.
- Simultaneous events: A[5] and A[2] rise together -> Q=6'b100100, FIRST=2. Later A[0] rises -> FIRST stays 2. Clear bit 2 only -> FIRST stays 2, FV=1. Clear all -> FV=0.
- Masking: Q=6'b010000, MASK 6'h3F -> 6'h2F -> Z0 goes 1 -> 0 one edge after the MASK change, Q unchanged. Restore MASK -> Z0=1.
- Level mode (EDGE_MODE=0) plus mid-op reset: A[4] held high, CLR[4]=1 held -> Q[4] remains 1. Assert RN asynchronously between edges -> Q, Z0, FV go 0 before the next CK edge.
